// File: rtl/branch_predict_cnt_pkg.sv
// Shared encodings for the branch predictor: jump/branch types, next-PC select
// and the reset value of each 2-bit history counter.
package branch_predict_cnt_pkg;

  typedef enum logic [1:0] {
    J_NONE   = 2'b00,
    J_JAL    = 2'b01,
    J_JALR   = 2'b10,
    J_BRANCH = 2'b11
  } j_type_e;

  typedef enum logic [2:0] {
    BT_BEQ  = 3'b000,
    BT_BNE  = 3'b001,
    BT_RSV2 = 3'b010,
    BT_RSV3 = 3'b011,
    BT_BLT  = 3'b100,
    BT_BGE  = 3'b101,
    BT_BLTU = 3'b110,
    BT_BGEU = 3'b111
  } branch_t_e;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_TGT     = 2'b01,
    PC_JALR    = 2'b10,
    PC_RECOVER = 2'b11
  } pc_sel_e;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] WNT = 2'b01;

  typedef struct packed {
    logic    flush;
    pc_sel_e pc_sel;
    logic    mispredict;
  } resolve_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter; one per branch-history entry.
module sat_counter2
  import branch_predict_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  output logic [1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WNT;
    end else if (en) begin
      if (up && state != 2'b11)
        state <= state + 2'd1;
      else if (!up && state != 2'b00)
        state <= state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_cnt.sv
// Bimodal branch predictor with EX-stage resolution, flush/next-PC select
// and a saturating mispredict counter.
module branch_predict_cnt
  import branch_predict_cnt_pkg::*;
#(
  parameter int   DEPTH  = 64,
  parameter int   PC_W   = 32,
  parameter int   STAT_W = 16,
  localparam int  IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred,
  input  logic [1:0]        j_type,
  input  logic [2:0]        branch_t,
  input  logic              zero,
  input  logic              sign_bit,
  input  logic              carry,
  output logic              flush,
  output logic [1:0]        pc_sel,
  output logic [STAT_W-1:0] mispredict_cnt
);

  function automatic logic branch_taken(input logic [2:0] bt, input logic z,
                                        input logic s, input logic c);
    logic t;
    case (branch_t_e'(bt))
      BT_BEQ:  t = z;
      BT_BNE:  t = ~z;
      BT_BLT:  t = s;
      BT_BGE:  t = ~s;
      BT_BLTU: t = c;
      BT_BGEU: t = ~c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [DEPTH-1:0][1:0] ctr;
  logic [IDX_W-1:0]      if_idx, ex_idx;
  logic                  taken, upd_en;
  resolve_t              res;
  logic                  unused_pc;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign if_idx    = if_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc, ex_pc};

  assign taken  = branch_taken(branch_t, zero, sign_bit, carry);
  assign upd_en = ex_valid && (j_type_e'(j_type) == J_BRANCH);

  // No read/write bypass: the prediction always reflects the registered state.
  assign pred_taken = ~rst & ctr[if_idx][1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (upd_en && (ex_idx == IDX_W'(i))),
      .up    (taken),
      .state (ctr[i])
    );
  end

  always_comb begin
    res = '{flush: 1'b0, pc_sel: PC_SEQ, mispredict: 1'b0};
    if (ex_valid && !rst) begin
      case (j_type_e'(j_type))
        J_JAL: begin
          res.flush  = 1'b1;
          res.pc_sel = PC_TGT;
        end
        J_JALR: begin
          res.flush  = 1'b1;
          res.pc_sel = PC_JALR;
        end
        J_BRANCH: begin
          if (taken != ex_pred) begin
            res.flush      = 1'b1;
            res.mispredict = 1'b1;
            res.pc_sel     = taken ? PC_TGT : PC_RECOVER;
          end
        end
        default: ;
      endcase
    end
  end

  assign flush  = res.flush;
  assign pc_sel = res.pc_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mispredict_cnt <= '0;
    else if (res.mispredict && mispredict_cnt != '1)
      mispredict_cnt <= mispredict_cnt + 1'b1;
  end

endmodule

// File: tb/tb_branch_predict_cnt.sv
// Directed bench for branch_predict_cnt (DEPTH=4, STAT_W=4) with an
// integer-level reference model checked every cycle.
module tb_branch_predict_cnt;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int STAT_W = 4;
  localparam int CMAX   = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PC_W-1:0]   if_pc = '0;
  logic              pred_taken;
  logic              ex_valid = 1'b0;
  logic [PC_W-1:0]   ex_pc = '0;
  logic              ex_pred = 1'b0;
  logic [1:0]        j_type = 2'b00;
  logic [2:0]        branch_t = 3'b000;
  logic              zero = 1'b0, sign_bit = 1'b0, carry = 1'b0;
  logic              flush;
  logic [1:0]        pc_sel;
  logic [STAT_W-1:0] mispredict_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit running = 1'b1;

  always #5 clk = ~clk;

  branch_predict_cnt #(.DEPTH(DEPTH), .PC_W(PC_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred(ex_pred), .j_type(j_type),
    .branch_t(branch_t), .zero(zero), .sign_bit(sign_bit), .carry(carry),
    .flush(flush), .pc_sel(pc_sel), .mispredict_cnt(mispredict_cnt)
  );

  // Reference model: counters as integers 0..3, mispredicts as an integer.
  int m_ctr[DEPTH];
  int m_cnt;

  function automatic int idx(input logic [PC_W-1:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic bit m_taken(input logic [2:0] bt, input bit z, input bit s, input bit c);
    case (bt)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return s;
      3'd5: return !s;
      3'd6: return c;
      3'd7: return !c;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit t;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_ctr[i] <= 1;
      m_cnt <= 0;
    end else if (ex_valid && j_type == 2'b11) begin
      t = m_taken(branch_t, zero, sign_bit, carry);
      m_ctr[idx(ex_pc)] <= t ? ((m_ctr[idx(ex_pc)] == 3) ? 3 : m_ctr[idx(ex_pc)] + 1)
                             : ((m_ctr[idx(ex_pc)] == 0) ? 0 : m_ctr[idx(ex_pc)] - 1);
      if (t != ex_pred) m_cnt <= (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int f, sel;
    bit t;
    if (running) begin
      f = 0; sel = 0;
      if (!rst && ex_valid) begin
        case (j_type)
          2'b01: begin f = 1; sel = 1; end
          2'b10: begin f = 1; sel = 2; end
          2'b11: begin
            t = m_taken(branch_t, zero, sign_bit, carry);
            if (t && !ex_pred) begin f = 1; sel = 1; end
            else if (!t && ex_pred) begin f = 1; sel = 3; end
          end
          default: ;
        endcase
      end
      check("model_pred_taken", int'(pred_taken), int'(!rst && m_ctr[idx(if_pc)] >= 2));
      check("model_flush", int'(flush), f);
      check("model_pc_sel", int'(pc_sel), sel);
      check("model_mispredict_cnt", int'(mispredict_cnt), m_cnt);
    end
  end

  task automatic drive(input bit v, input logic [PC_W-1:0] pc, input bit p,
                       input logic [1:0] jt, input logic [2:0] bt,
                       input bit z, input bit s, input bit c);
    ex_valid = v; ex_pc = pc; ex_pred = p; j_type = jt; branch_t = bt;
    zero = z; sign_bit = s; carry = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a branch pending that must be discarded.
    if_pc = 32'h40;
    drive(1, 32'h40, 0, 2'b11, 3'b000, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", int'(flush), 0);
    check("rst_pc_sel", int'(pc_sel), 0);
    check("rst_pred", int'(pred_taken), 0);
    check("rst_cnt", int'(mispredict_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 32'h0, 0, 2'b00, 3'b000, 0, 0, 0);
    check("pred_0x40_after_rst", int'(pred_taken), 0);

    // Two taken BEQs at 0x40 train entry 0 to strongly taken.
    drive(1, 32'h40, 0, 2'b11, 3'b000, 1, 0, 0);
    check("beq_mis_flush", int'(flush), 1);
    check("beq_mis_sel", int'(pc_sel), 1);
    tick();
    drive(1, 32'h40, 1, 2'b11, 3'b000, 1, 0, 0);
    check("beq_ok_flush", int'(flush), 0);
    tick();
    drive(0, 32'h0, 0, 2'b00, 3'b000, 0, 0, 0);
    check("train_pred", int'(pred_taken), 1);
    check("train_cnt", int'(mispredict_cnt), 1);

    // Walk the entry down with not-taken BNEs: 10, 01, 00, 00.
    drive(1, 32'h40, 1, 2'b11, 3'b001, 1, 0, 0);
    check("bne_sel", int'(pc_sel), 3);
    tick();
    check("down1_pred", int'(pred_taken), 1);
    tick();
    check("down2_pred", int'(pred_taken), 0);
    tick();
    tick();
    drive(0, 32'h0, 0, 2'b00, 3'b000, 0, 0, 0);
    check("down4_pred", int'(pred_taken), 0);
    check("down_cnt", int'(mispredict_cnt), 5);

    // BLT predicted taken resolves not-taken; BGEU predicted not-taken resolves taken.
    drive(1, 32'h44, 1, 2'b11, 3'b100, 0, 0, 0);
    check("blt_flush", int'(flush), 1);
    check("blt_sel", int'(pc_sel), 3);
    tick();
    check("blt_cnt", int'(mispredict_cnt), 6);
    drive(1, 32'h48, 0, 2'b11, 3'b111, 0, 0, 0);
    check("bgeu_flush", int'(flush), 1);
    check("bgeu_sel", int'(pc_sel), 1);
    tick();
    check("bgeu_cnt", int'(mispredict_cnt), 7);
    drive(1, 32'h4C, 1, 2'b11, 3'b010, 1, 1, 1);
    check("rsv_sel", int'(pc_sel), 3);
    tick();
    drive(1, 32'h4C, 0, 2'b11, 3'b000, 0, 0, 0);
    check("ok_flush", int'(flush), 0);
    tick();
    check("ok_cnt", int'(mispredict_cnt), 8);

    // Jumps and bubbles leave the table and counter alone.
    if_pc = 32'h48;
    drive(1, 32'h48, 0, 2'b10, 3'b001, 1, 0, 0);
    check("jalr_flush", int'(flush), 1);
    check("jalr_sel", int'(pc_sel), 2);
    tick();
    drive(1, 32'h48, 1, 2'b01, 3'b001, 1, 0, 0);
    check("jal_sel", int'(pc_sel), 1);
    tick();
    drive(0, 32'h48, 0, 2'b10, 3'b001, 1, 0, 0);
    check("bubble_flush", int'(flush), 0);
    check("bubble_sel", int'(pc_sel), 0);
    tick();
    drive(0, 32'h48, 1, 2'b11, 3'b001, 1, 0, 0);
    tick();
    drive(1, 32'h48, 1, 2'b00, 3'b001, 1, 0, 0);
    tick();
    check("jump_pred", int'(pred_taken), 1);
    check("jump_cnt", int'(mispredict_cnt), 8);

    // Aliasing: 0x00 and 0x10 share entry 0 (currently 00).
    if_pc = 32'h10;
    drive(1, 32'h00, 0, 2'b11, 3'b000, 1, 0, 0);
    tick();
    check("alias1_pred", int'(pred_taken), 0);
    check("alias_same_cycle_old", int'(pred_taken), 0);
    tick();
    check("alias2_pred", int'(pred_taken), 1);
    check("alias_cnt", int'(mispredict_cnt), 10);

    // Saturate the mispredict counter.
    drive(1, 32'h44, 0, 2'b11, 3'b000, 1, 0, 0);
    repeat (17) tick();
    drive(0, 32'h0, 0, 2'b00, 3'b000, 0, 0, 0);
    check("cnt_sat", int'(mispredict_cnt), 15);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", int'(mispredict_cnt), 0);
    for (int i = 0; i < DEPTH; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check("async_rst_pred", int'(pred_taken), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if_pc = 32'(i * 4);
      drive(1, 32'(i * 4), 1, 2'b11, 3'b000, 1, 0, 0);
      tick();
      check("post_rst_wnt_pred", int'(pred_taken), 1);
    end
    drive(0, 32'h0, 0, 2'b00, 3'b000, 0, 0, 0);
    tick();

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
